// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types for the run controller.
//   state_t  - run controller FSM states
//   status_t - packed {done, timed_out} status encoding and its three legal values
//   cw()     - counter width helper (never returns 0)
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        RUN,
        HALTED,
        TIMEOUT
    } state_t;

    typedef struct packed {
        logic done;
        logic timed_out;
    } status_t;

    localparam status_t STAT_CLEAR = '{done: 1'b0, timed_out: 1'b0};
    localparam status_t STAT_HALT  = '{done: 1'b1, timed_out: 1'b0};
    localparam status_t STAT_TOUT  = '{done: 1'b1, timed_out: 1'b1};

    // Bits needed to hold values 0..n-1, at least one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_ctrl_pc_stall_detect.sv
// pc_stall_detect: detects a PC self-loop held for HALT_HOLD samples.
//   clk, reset  - clock, async active-low reset
//   clr         - clears last_pc and the repeat counter (new run)
//   sample      - pc is a valid, enabled sample this cycle
//   pc          - observed PC
//   halt        - combinational pulse: this sample completes the self-loop
module pc_stall_detect
    import run_ctrl_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int HALT_HOLD = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            sample,
    input  logic [PC_W-1:0] pc,
    output logic            halt
);

    localparam int RW = cw(HALT_HOLD);
    localparam logic [RW-1:0] REP_MAX = RW'(HALT_HOLD - 1);

    logic [PC_W-1:0] last_pc;
    logic [RW-1:0]   rep;
    logic            same;

    assign same = (pc == last_pc);
    assign halt = sample && same && (rep == REP_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc <= '0;
            rep     <= '0;
        end else if (clr) begin
            last_pc <= '0;
            rep     <= '0;
        end else if (sample) begin
            last_pc <= pc;
            if (!same)
                rep <= '0;
            else if (rep != REP_MAX)
                rep <= rep + 1'b1;   // saturate; the halt fires at REP_MAX anyway
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run controller for the CPU core. Holds the core in reset for
// RST_CYCLES after start, then counts enabled cycles until the PC self-loops
// (halt) or the MAX_CYCLES budget runs out (timeout).
// Optional build macro: RUN_CTRL_STEP_EN adds step_mode/step single-step inputs.
// Ports:
//   clk, reset        - clock, async active-low reset
//   start             - one-cycle launch pulse (ignored in RST_HOLD/RUN)
//   pc, pc_valid      - observed PC and its valid qualifier
//   step_mode, step   - (RUN_CTRL_STEP_EN only) single-step control
//   core_rst, core_en - core reset / clock enable
//   running, done, timed_out - status (done/timed_out sticky until next start)
//   cycle_cnt         - enabled cycles executed in RUN
//   halt_pc           - PC at which halt was detected
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 1,
    parameter int MAX_CYCLES = 2000,
    parameter int HALT_HOLD  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_valid,
`ifdef RUN_CTRL_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic             core_rst,
    output logic             core_en,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [PC_W-1:0]  halt_pc
);

    localparam int HW = cw(RST_CYCLES);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    status_t           stat_q, stat_d;
    logic [PC_W-1:0]   hpc_q, hpc_d;
    logic              rst_q, rst_d;
    logic              en_q, en_d;
    logic              run_q, run_d;

    logic step_mode_i, step_i;
`ifdef RUN_CTRL_STEP_EN
    assign step_mode_i = step_mode;
    assign step_i      = step;
`else
    assign step_mode_i = 1'b0;
    assign step_i      = 1'b0;
`endif

    logic launch, run_en, sample, halt, tout;

    assign launch = start && (state_q == IDLE || state_q == HALTED || state_q == TIMEOUT);
    assign run_en = (state_q == RUN) && en_q;
    assign sample = run_en && pc_valid;
    assign tout   = run_en && (cnt_q == CNT_LAST);

    pc_stall_detect #(
        .PC_W      (PC_W),
        .HALT_HOLD (HALT_HOLD)
    ) u_stall (
        .clk    (clk),
        .reset  (reset),
        .clr    (launch),
        .sample (sample),
        .pc     (pc),
        .halt   (halt)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        stat_d  = stat_q;
        hpc_d   = hpc_q;
        rst_d   = rst_q;
        en_d    = en_q;
        run_d   = run_q;
        case (state_q)
            IDLE, HALTED, TIMEOUT: begin
                if (launch) begin
                    state_d = RST_HOLD;
                    hold_d  = '0;
                    cnt_d   = '0;
                    stat_d  = STAT_CLEAR;
                    rst_d   = 1'b1;
                    en_d    = 1'b1;
                    run_d   = 1'b0;
                end
            end
            RST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    rst_d   = 1'b0;
                    run_d   = 1'b1;
                    en_d    = !step_mode_i || step_i;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (run_en)
                    cnt_d = cnt_q + 1'b1;
                // In step mode a pulse grants one enable cycle; a pulse seen
                // during that cycle is dropped.
                en_d = !step_mode_i || (step_i && !en_q);
                if (halt) begin
                    state_d = HALTED;
                    stat_d  = STAT_HALT;
                    hpc_d   = pc;
                    en_d    = 1'b0;
                    run_d   = 1'b0;
                end else if (tout) begin
                    state_d = TIMEOUT;
                    stat_d  = STAT_TOUT;
                    en_d    = 1'b0;
                    run_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rst_d   = 1'b1;
                en_d    = 1'b0;
                run_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            stat_q  <= STAT_CLEAR;
            hpc_q   <= '0;
            rst_q   <= 1'b1;
            en_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            stat_q  <= stat_d;
            hpc_q   <= hpc_d;
            rst_q   <= rst_d;
            en_q    <= en_d;
            run_q   <= run_d;
        end
    end

    assign core_rst  = rst_q;
    assign core_en   = en_q;
    assign running   = run_q;
    assign done      = stat_q.done;
    assign timed_out = stat_q.timed_out;
    assign cycle_cnt = cnt_q;
    assign halt_pc   = hpc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl
// (RST_CYCLES=3, MAX_CYCLES=10, HALT_HOLD=4).
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic        pc_valid;
    logic        step_mode;
    logic        step;
    logic        core_rst, core_en, running, done, timed_out;
    logic [31:0] cycle_cnt, halt_pc;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .PC_W       (32),
        .CNT_W      (32),
        .RST_CYCLES (3),
        .MAX_CYCLES (10),
        .HALT_HOLD  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pc        (pc),
        .pc_valid  (pc_valid),
`ifdef RUN_CTRL_STEP_EN
        .step_mode (step_mode),
        .step      (step),
`endif
        .core_rst  (core_rst),
        .core_en   (core_en),
        .running   (running),
        .done      (done),
        .timed_out (timed_out),
        .cycle_cnt (cycle_cnt),
        .halt_pc   (halt_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Launch a run: start pulse, then the 3 reset-hold cycles; returns in RUN with cnt 0.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clr_done", done, 0);
        chk("start_clr_cnt", cycle_cnt, 0);
        repeat (3) tick();
    endtask

    logic [31:0] seq [8];
    int ens;

    initial begin
        reset = 1'b0; start = 1'b0; pc = '0; pc_valid = 1'b0;
        step_mode = 1'b0; step = 1'b0;
        tick(); tick();
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_en", core_en, 0);
        chk("rst_halt_pc", halt_pc, 0);
        reset = 1'b1;
        repeat (50) tick();
        chk("idle_core_rst", core_rst, 1);
        chk("idle_core_en", core_en, 0);
        chk("idle_running", running, 0);
        chk("idle_done", done, 0);
        chk("idle_tout", timed_out, 0);
        chk("idle_cnt", cycle_cnt, 0);

        // reset hold lasts exactly 3 cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_core_rst", core_rst, 1);
            chk("hold_core_en", core_en, 1);
            chk("hold_running", running, 0);
            tick();
        end
        chk("run_core_rst", core_rst, 0);
        chk("run_running", running, 1);
        chk("run_cnt0", cycle_cnt, 0);

        // halt on 5th 0x300c sample
        seq = '{32'h3000, 32'h3004, 32'h3008, 32'h300c, 32'h300c, 32'h300c, 32'h300c, 32'h300c};
        pc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = seq[i];
            tick();
            if (i < 3) chk("run_cnt", cycle_cnt, i + 1);
            if (i == 6) chk("halt_early", done, 0);
        end
        chk("halt_done", done, 1);
        chk("halt_tout", timed_out, 0);
        chk("halt_pc", halt_pc, 32'h300c);
        chk("halt_core_en", core_en, 0);
        chk("halt_running", running, 0);
        chk("halt_core_rst", core_rst, 0);
        chk("halt_cnt", cycle_cnt, 8);

        // timeout with incrementing PC; a start mid-run is ignored
        do_start();
        for (int i = 0; i < 10; i++) begin
            pc = 32'h4000 + 32'(4 * i);
            if (i == 5) start = 1'b1;
            tick();
            start = 1'b0;
            if (i == 5) chk("ign_start_running", running, 1);
            if (i == 8) begin
                chk("tout_early", done, 0);
                chk("tout_cnt9", cycle_cnt, 9);
            end
        end
        for (int r = 0; r < 6; r++) begin
            chk("tout_done", done, 1);
            chk("tout_flag", timed_out, 1);
            chk("tout_cnt", cycle_cnt, 10);
            chk("tout_core_en", core_en, 0);
            chk("tout_halt_pc_held", halt_pc, 32'h300c);
            pc = pc + 32'd4;
            tick();
        end

        // PC 0 repeated counts from the first sample; a bubble is not a sample
        do_start();
        pc = 32'h0;
        tick(); tick();
        pc_valid = 1'b0;
        tick();
        pc_valid = 1'b1;
        tick();
        chk("pc0_early", done, 0);
        tick();
        chk("pc0_done", done, 1);
        chk("pc0_halt_pc", halt_pc, 0);
        chk("pc0_cnt", cycle_cnt, 5);

        // halt and timeout in the same cycle: halt wins
        do_start();
        for (int i = 0; i < 10; i++) begin
            pc = (i < 5) ? 32'h10 + 32'(4 * i) : 32'h24;
            tick();
            if (i == 8) chk("coin_early", done, 0);
        end
        chk("coin_done", done, 1);
        chk("coin_tout", timed_out, 0);
        chk("coin_halt_pc", halt_pc, 32'h24);
        chk("coin_cnt", cycle_cnt, 10);

        // async reset mid-run
        do_start();
        for (int i = 0; i < 3; i++) begin
            pc = 32'h5000 + 32'(4 * i);
            tick();
        end
        chk("mid_running", running, 1);
        chk("mid_cnt", cycle_cnt, 3);
        chk("mid_halt_pc_held", halt_pc, 32'h24);
        #1 reset = 1'b0;
        #1;
        chk("arst_core_rst", core_rst, 1);
        chk("arst_core_en", core_en, 0);
        chk("arst_running", running, 0);
        chk("arst_done", done, 0);
        chk("arst_cnt", cycle_cnt, 0);
        chk("arst_halt_pc", halt_pc, 0);
        reset = 1'b1;
        tick();

`ifdef RUN_CTRL_STEP_EN
        // single-step: 3 pulses 5 cycles apart give 3 enabled cycles
        step_mode = 1'b1;
        pc_valid  = 1'b0;
        do_start();
        chk("step_idle_en", core_en, 0);
        ens = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (core_en) ens++;
            for (int j = 0; j < 4; j++) begin
                tick();
                if (core_en) ens++;
            end
        end
        chk("step_en_cycles", ens, 3);
        chk("step_cnt", cycle_cnt, 3);
        step_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Synthesizable run controller that drives the CPU core's clock-enable and core reset.
- Sequences a parametrised reset hold, then counts execution cycles.
- Detects program end as a PC self-loop (e.g. `beq $0,$0,-1`) held for N samples.
- Flags a timeout if the program does not end within a cycle budget. Sits between the top-level clock/reset and the pipelined core, replacing fixed-delay stop logic.

Parameters:
- PC_W, 32, width of the observed PC.
- CNT_W, 32, width of the cycle counter.
- RST_CYCLES, 1, cycles core_rst is held high after start (>=1).
- MAX_CYCLES, 2000, enabled-cycle budget before timeout (1..2^CNT_W-1).
- HALT_HOLD, 4, consecutive repeated-PC samples that declare halt (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that launches a run.
- pc  in  PC_W  PC of the instruction currently in the sampled stage.
- pc_valid  in  1  pc is meaningful this cycle (no bubble).
- core_rst  out  1  synchronous active-high reset to the core.
- core_en  out  1  clock-enable to the core.
- running  out  1  high in RUN.
- done  out  1  run finished (halt or timeout); sticky until next start.
- timed_out  out  1  run ended by budget; sticky until next start.
- cycle_cnt  out  CNT_W  enabled cycles executed in RUN.
- halt_pc  out  PC_W  PC at which halt was detected.

Behaviour:
- Reset (reset=0, async): state IDLE. Outputs: core_rst=1, core_en=0, running=0, done=0, timed_out=0, cycle_cnt=0, halt_pc=0. Internal last_pc=0, rep=0, hold counter=0.
- States: IDLE, RST_HOLD, RUN, HALTED, TIMEOUT.
- IDLE/HALTED/TIMEOUT + start:
  - Go to RST_HOLD next edge.
  - Clear done, timed_out, cycle_cnt, rep.
  - Hold halt_pc until the next halt.
- RST_HOLD:
  - core_rst=1, core_en=1, for exactly RST_CYCLES cycles.
  - Then RUN; core_rst=0 from the first RUN cycle.
- RUN:
  - running=1, core_en=1.
  - cycle_cnt increments on every cycle with core_en=1.
  - PC sample counts only when pc_valid=1 and core_en=1.
  - On a sample: if pc==last_pc then rep++, else rep=0. last_pc<=pc.
  - Halt condition: a sample arrives with pc==last_pc while rep==HALT_HOLD-1.
  - On halt, next edge: state HALTED, done=1, halt_pc=pc, core_en=0, running=0.
  - Timeout condition: enabled cycle with cycle_cnt==MAX_CYCLES-1.
  - On timeout, next edge: state TIMEOUT, cycle_cnt=MAX_CYCLES, done=1, timed_out=1, core_en=0.
  - Halt and timeout in the same cycle: halt wins (timed_out=0).
- start while in RST_HOLD or RUN: ignored.
- HALTED/TIMEOUT: core_en=0, core_rst=0. Core state is frozen for inspection.
- cycle_cnt never wraps; the maximum is MAX_CYCLES.
- The first PC sample after start compares against the last_pc cleared at start (0). PC 0 repeated therefore counts.
- Async reset mid-run: immediate return to IDLE values. The core is held in reset via core_rst=1.
- All outputs are registered; latency from condition to done is one cycle.

Optional Feature:
- Macro: RUN_CTRL_STEP_EN.
- When defined:
  - Adds inputs step_mode (1) and step (1).
  - In RUN with step_mode=1, core_en=0 except for exactly one cycle following each step pulse.
  - A step pulse that arrives while that enable cycle is in progress is dropped.
  - cycle_cnt and PC sampling advance only on enabled cycles.
  - step_mode=0 behaves as free-run.
- When undefined: the ports do not exist and core_en=1 throughout RUN and RST_HOLD.

Decomposition:
- Package run_ctrl_pkg holds:
  - the state enum (IDLE, RST_HOLD, RUN, HALTED, TIMEOUT);
  - a status encoding {done, timed_out}.
- Sub-module pc_stall_detect (last_pc register, rep counter, halt pulse output), parametrised by PC_W and HALT_HOLD.
- The FSM, counters and enable gating stay in run_ctrl.

Test Plan:
- Reset release, no start, 50 cycles -> IDLE, core_rst=1, core_en=0, done=0, cycle_cnt=0.
- RST_CYCLES=3; start -> core_rst high for exactly 3 cycles, then running=1 and cycle_cnt counts 1,2,3…
- HALT_HOLD=4; PC sequence 0x3000,0x3004,0x3008, then 0x300c repeated -> done=1 the cycle after the 5th 0x300c sample; halt_pc=0x300c; timed_out=0; core_en=0.
- MAX_CYCLES=10; PC always incrementing -> done=1, timed_out=1, cycle_cnt=10; 5 further cycles leave everything unchanged.
- Halt and timeout coincide in the same cycle -> timed_out=0, done=1, halt_pc set. A second start clears done and cycle_cnt and re-runs; reset pulsed mid-RUN -> immediate IDLE values.
- With RUN_CTRL_STEP_EN, step_mode=1 and 3 step pulses spaced 5 cycles apart -> exactly 3 core_en cycles and cycle_cnt=3.
